// File: rtl/rnn_pkg.sv
// ---------------------------------------------------------------------------
// rnn_pkg
// Shared types and helpers for the RNN datapath stages.
//   act_mode_t : activation selector (identity, ReLU, hard-tanh, hard-sigmoid)
//   Q_ONE      : 1.0 in signed Q8.8
//   Q_HALF     : 0.5 in signed Q8.8
//   sat16      : clamp a 17-bit signed sum into the 16-bit signed range
// ---------------------------------------------------------------------------
package rnn_pkg;

    typedef enum logic [1:0] {
        ACT_ID    = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_HTANH = 2'd2,
        ACT_HSIG  = 2'd3
    } act_mode_t;

    localparam logic signed [15:0] Q_ONE  = 16'sd256;
    localparam logic signed [15:0] Q_HALF = 16'sd128;

    localparam logic signed [16:0] SAT_MAX = 17'sd32767;
    localparam logic signed [16:0] SAT_MIN = -17'sd32768;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/act_unit.sv
// ---------------------------------------------------------------------------
// act_unit
// Combinational activation on a signed Q8.8 value.
//   mode : activation select (act_mode_t)
//   x    : signed Q8.8 input
//   y    : signed Q8.8 activated output
// ---------------------------------------------------------------------------
module act_unit
    import rnn_pkg::*;
(
    input  act_mode_t          mode,
    input  logic signed [15:0] x,
    output logic signed [15:0] y
);

    logic signed [15:0] hs;

    always_comb begin
        // x >>> 2 lies in [-8192, 8191], so adding 0.5 cannot overflow 16 bits.
        hs = (x >>> 2) + Q_HALF;
        y  = x;
        case (mode)
            ACT_ID: begin
                y = x;
            end
            ACT_RELU: begin
                y = x[15] ? 16'sd0 : x;
            end
            ACT_HTANH: begin
                if (x > Q_ONE) begin
                    y = Q_ONE;
                end else if (x < -Q_ONE) begin
                    y = -Q_ONE;
                end else begin
                    y = x;
                end
            end
            ACT_HSIG: begin
                if (hs[15]) begin
                    y = 16'sd0;
                end else if (hs > Q_ONE) begin
                    y = Q_ONE;
                end else begin
                    y = hs;
                end
            end
            default: begin
                y = x;
            end
        endcase
    end

endmodule

// File: rtl/bias_act.sv
// ---------------------------------------------------------------------------
// bias_act
// Post-matmul stage: walks the matmul result vector, adds a saturating
// per-element bias, applies the selected activation and writes the result
// into the hidden-state tensor.
//   clk, rst_n            : clock, async active-low reset
//   start, act_mode       : launch a pass (sampled in IDLE), activation select
//   ready, busy, done     : IDLE flag, non-IDLE flag, pulse on final write
//   src_sel / src_data    : matmul read index and its combinational data
//   bias_sel / bias_data  : bias read index (mirrors src_sel) and its data
//   dst_write/sel/data    : hidden-state write port
//
// state | meaning
// IDLE  | waiting for start; ready high
// RUN   | reading element idx; stage A captures sum each edge
// FLUSH | last sum moves to the output registers
// LAST  | final write on the port; done high
// ---------------------------------------------------------------------------
module bias_act
    import rnn_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int IDX_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              act_mode,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        src_sel,
    input  logic signed [15:0]      src_data,
    output logic [IDX_W-1:0]        bias_sel,
    input  logic signed [15:0]      bias_data,
    output logic                    dst_write,
    output logic [IDX_W-1:0]        dst_sel,
    output logic signed [15:0]      dst_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_LAST  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    act_mode_t           mode_q;

    logic signed [15:0]  sum_q;
    logic [IDX_W-1:0]    sum_idx_q;
    logic                a_valid_q;

    logic signed [16:0]  sum_wide;
    logic signed [15:0]  act_y;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_LAST;
            end
            S_LAST: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- index and mode ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            mode_q <= ACT_ID;
        end else begin
            if (state_q == S_IDLE && start) begin
                idx_q  <= '0;
                mode_q <= act_mode_t'(act_mode);
            end else if (state_q == S_RUN) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Reads are only issued in RUN; elsewhere the select parks at 0.
    assign src_sel  = (state_q == S_RUN) ? idx_q : '0;
    assign bias_sel = src_sel;

    // ---------------- stage A: saturating bias add ----------------
    assign sum_wide = {src_data[15], src_data} + {bias_data[15], bias_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            sum_idx_q <= '0;
            a_valid_q <= 1'b0;
        end else begin
            a_valid_q <= (state_q == S_RUN);
            if (state_q == S_RUN) begin
                sum_q     <= sat16(sum_wide);
                sum_idx_q <= idx_q;
            end
        end
    end

    // ---------------- stage B: activation and write ----------------
    act_unit u_act (
        .mode (mode_q),
        .x    (sum_q),
        .y    (act_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_write <= 1'b0;
            dst_sel   <= '0;
            dst_data  <= '0;
        end else begin
            dst_write <= a_valid_q;
            if (a_valid_q) begin
                dst_sel  <= sum_idx_q;
                dst_data <= act_y;
            end
        end
    end

endmodule

// File: tb/tb_bias_act.sv
module tb_bias_act;

    localparam int LEN   = 4;
    localparam int IDX_W = 2;

    typedef struct {
        int sel;
        int data;
        bit last;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [1:0]         act_mode;
    logic               ready;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   src_sel;
    logic signed [15:0] src_data;
    logic [IDX_W-1:0]   bias_sel;
    logic signed [15:0] bias_data;
    logic               dst_write;
    logic [IDX_W-1:0]   dst_sel;
    logic signed [15:0] dst_data;

    logic [15:0] src_mem  [LEN];
    logic [15:0] bias_mem [LEN];

    exp_t q[$];
    int   total;
    int   bad;
    int   wr_seen;

    assign src_data  = src_mem[src_sel];
    assign bias_data = bias_mem[bias_sel];

    bias_act #(.LEN(LEN), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .act_mode  (act_mode),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .src_sel   (src_sel),
        .src_data  (src_data),
        .bias_sel  (bias_sel),
        .bias_data (bias_data),
        .dst_write (dst_write),
        .dst_sel   (dst_sel),
        .dst_data  (dst_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dst_write) begin
                wr_seen++;
                if (q.size() == 0) begin
                    chk("unexpected write sel", int'(dst_sel), -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("write sel",  int'(dst_sel), e.sel);
                    chk("write data", int'(dst_data), e.data);
                    chk("write done", int'(done), int'(e.last));
                end
            end else if (done) begin
                chk("done without write", int'(done), 0);
            end
            if (busy) begin
                chk("bias_sel mirrors src_sel", int'(bias_sel), int'(src_sel));
            end else begin
                chk("src_sel parked", int'(src_sel), 0);
            end
        end
    end

    task automatic load(input int s[4], input int b[4], input int e[4]);
        for (int k = 0; k < LEN; k++) begin
            src_mem[k]  = s[k][15:0];
            bias_mem[k] = b[k][15:0];
            q.push_back('{k, e[k], (k == LEN - 1)});
        end
    endtask

    task automatic run_pass(input logic [1:0] mode, input int s[4], input int b[4],
                            input int e[4], input string tag);
        int cyc;
        load(s, b, e);
        @(posedge clk); #1;
        act_mode = mode;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        repeat (50) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
        end
        chk({tag, " busy cycles"}, cyc, LEN + 2);
        chk({tag, " queue drained"}, q.size(), 0);
        chk({tag, " ready after"}, int'(ready), 1);
    endtask

    initial begin
        int cyc;
        int base;
        total    = 0;
        bad      = 0;
        wr_seen  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        act_mode = 2'd0;
        for (int k = 0; k < LEN; k++) begin
            src_mem[k]  = '0;
            bias_mem[k] = '0;
        end
        #12;
        chk("reset ready",     int'(ready), 1);
        chk("reset busy",      int'(busy), 0);
        chk("reset done",      int'(done), 0);
        chk("reset src_sel",   int'(src_sel), 0);
        chk("reset dst_write", int'(dst_write), 0);
        chk("reset dst_sel",   int'(dst_sel), 0);
        chk("reset dst_data",  int'(dst_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_pass(2'd0, '{256, -256, 32767, 0}, '{1, 1, 1, -5},
                 '{257, -255, 32767, -5}, "identity");
        run_pass(2'd1, '{-300, 300, -1, 0}, '{0, 0, 0, 0},
                 '{0, 300, 0, 0}, "relu");
        run_pass(2'd0, '{-32768, 32000, 0, 0}, '{-1, 1000, 0, 0},
                 '{-32768, 32767, 0, 0}, "saturate");
        run_pass(2'd2, '{-1000, -100, 100, 1000}, '{0, 0, 0, 0},
                 '{-256, -100, 100, 256}, "htanh");
        run_pass(2'd3, '{-1000, -100, 100, 1000}, '{0, 0, 0, 0},
                 '{0, 103, 153, 256}, "hsig");

        // Handshake: start pulses in RUN and LAST are ignored; mode change mid-pass is ignored.
        load('{-300, 300, -1, 0}, '{0, 0, 0, 0}, '{0, 300, 0, 0});
        @(posedge clk); #1;
        act_mode = 2'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        act_mode = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) break;
            cyc++;
        end
        chk("handshake reached LAST", int'(done), 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("start in LAST ignored", int'(busy), 0);
        chk("handshake queue drained", q.size(), 0);
        run_pass(2'd0, '{-300, 300, -1, 0}, '{0, 0, 0, 0},
                 '{-300, 300, -1, 0}, "second pass");

        // Reset after the 2nd write of a pass.
        src_mem[0] = 16'd10; src_mem[1] = 16'd20; src_mem[2] = 16'd30; src_mem[3] = 16'd40;
        for (int k = 0; k < LEN; k++) bias_mem[k] = '0;
        q.push_back('{0, 10, 1'b0});
        q.push_back('{1, 20, 1'b0});
        base = wr_seen;
        @(posedge clk); #1;
        act_mode = 2'd0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(negedge clk); #1;
            if (wr_seen >= base + 2) break;
        end
        chk("writes before reset", wr_seen - base, 2);
        rst_n = 1'b0;
        #1;
        chk("reset abort dst_write", int'(dst_write), 0);
        chk("reset abort ready", int'(ready), 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready after release", int'(ready), 1);
        chk("busy after release", int'(busy), 0);
        chk("reset queue drained", q.size(), 0);
        base = wr_seen;
        repeat (8) @(negedge clk);
        chk("no writes after reset", wr_seen - base, 0);

        run_pass(2'd1, '{5, -5, 7, -7}, '{0, 0, 0, 0},
                 '{5, 0, 7, 0}, "post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bias_act.md
Name: bias_act

Overview:
- Post-matmul stage of the RNN datapath.
- Walks the matmul intermediate vector by index and adds a per-element bias with saturation.
- Applies a selectable activation and writes each result into the hidden-state tensor.
- The layer controller starts it once matmul reports ready; it drives matmul's external read select.

Parameters:
- LEN, 4: number of vector elements; must equal the matmul column count.
- IDX_W, 2: index width; must be at least clog2(LEN), minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  launch a pass over all LEN elements; sampled only in IDLE.
- act_mode  in  2  0 identity, 1 ReLU, 2 hard-tanh, 3 hard-sigmoid; latched at start.
- ready  out  1  high only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse coincident with the last write.
- src_sel  out  IDX_W  read index into matmul result vector (matmul sel).
- src_data  in  16  matmul data_out; combinational from src_sel, valid in the same cycle.
- bias_sel  out  IDX_W  bias memory read index; always equal to src_sel.
- bias_data  in  16  bias word; combinational from bias_sel, valid in the same cycle.
- dst_write  out  1  hidden-state tensor write enable.
- dst_sel  out  IDX_W  hidden-state write index.
- dst_data  out  16  activated result.

Behaviour:
- Number format: all data is signed Q8.8 (1.0 = 256).
- Reset values: all registers clear; ready=1, busy=0, done=0, src_sel=0, dst_write=0, dst_sel=0, dst_data=0.
  - rst_n low mid-pass aborts immediately. No further dst_write, return to IDLE, the pass is not resumed.
- States:
  - IDLE: start=1 -> RUN; idx<=0; latch act_mode.
  - RUN: src_sel=idx. At each edge, capture sum[idx] and set the stage-A valid bit. idx==LEN-1 -> FLUSH, else idx++.
  - FLUSH: one cycle; the last element moves from the sum register to the output registers -> LAST.
  - LAST: one cycle; the final dst_write is high and done=1 -> IDLE.
- start during RUN/FLUSH/LAST is ignored, not queued.
- start while already in IDLE on the LAST->IDLE edge: accepted on the next edge (ready must be seen high first).
- Pipeline:
  - Stage A: sum = sat16(src_data + bias_data), computed 17-bit and clamped to [-32768, 32767], registered with its index.
  - Stage B: act(sum) registered into dst_data and dst_sel; dst_write <= stage-A valid.
- Latency (start sampled at edge E0):
  - Element k is read during E(k)..E(k+1) and written during E(k+2)..E(k+3).
  - Total busy = LEN+2 cycles.
  - Exactly LEN write pulses per pass, in ascending dst_sel order, one per cycle with no gaps.
- Activations, on 16-bit signed x:
  - identity: x.
  - ReLU: x<0 ? 0 : x.
  - hard-tanh: clamp x to [-256, 256].
  - hard-sigmoid: (x >>> 2) + 128, clamped to [0, 256]; the shift floors toward negative infinity.
- Index bounds: src_sel and bias_sel never exceed LEN-1. When not RUN they hold 0.
- LEN=1: the pass is RUN (1 cycle), FLUSH, LAST; busy = 3 cycles.

Decomposition:
- Shared package rnn_pkg:
  - act_mode_t enum {ACT_ID, ACT_RELU, ACT_HTANH, ACT_HSIG}.
  - Q8.8 constants Q_ONE=256 and Q_HALF=128.
  - The sat16 function.
- One sub-module: act_unit, combinational, in act_mode_t + 16-bit x, out 16-bit y. Reused by later gate stages.

Test Plan:
- Identity, LEN=4:
  - Stimulus: src={256, -256, 32767, 0}, bias={1, 1, 1, -5}.
  - Required: writes {257, -255, 32767, -5} at dst_sel 0..3 on consecutive cycles; done on the 4th write; busy exactly 6 cycles.
- ReLU:
  - Stimulus: src={-300, 300, -1, 0}, bias=0.
  - Required: {0, 300, 0, 0}.
- Saturation:
  - Stimulus: src=-32768 with bias=-1 -> required -32768; src=32000 with bias=1000 -> required 32767 (identity).
- Hard-tanh / hard-sigmoid:
  - Stimulus: x = {-1000, -100, 100, 1000}.
  - Required htanh: {-256, -100, 100, 256}.
  - Required hsig: {0, 103, 153, 256}.
  - Note -100 >>> 2 = -25, +128 gives 103.
- Handshake:
  - Stimulus: pulse start again during RUN and during LAST.
  - Required: ignored, no extra writes. A start after ready rises runs a second full pass. act_mode changed mid-pass has no effect.
- Reset mid-pass:
  - Stimulus: assert rst_n low after the 2nd write.
  - Required: dst_write=0 immediately, ready=1 after release, no further writes until a new start.
